// File: rtl/stream_producer.sv
// ---------------------------------------------------------------------------
// stream_producer
//
// Transmit end of a 32-bit vld/rdy stream. Local logic pushes words into a
// small FIFO, and the block presents them in order on vld/data toward the
// consumer. The FIFO absorbs consumer backpressure, so the write side does not
// have to track it.
//
// Handshake: a beat transfers on a rising clk edge where vld && rdy. Once vld
// is high it stays high, and data stays unchanged, until that transfer
// happens. Reset is the only exception. vld is never a function of rdy.
//
// Optional feature: define STREAM_PRODUCER_LAST_EN to add the `last` output
// and the burst counter behind it. This marks every BURST_LEN-th beat.
//
// Parameters:
//   WIDTH      stream data width in bits
//   DEPTH      FIFO entries (power of 2, >= 2)
//   BURST_LEN  beats per burst for `last` (>= 1)
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   push wr_data this cycle
//   wr_data  in   word to enqueue
//   wr_full  out  FIFO full; a push this cycle is dropped
//   vld      out  data holds a valid beat
//   rdy      in   consumer accepts the beat
//   data     out  head-of-FIFO word (0 when empty)
//   level    out  current occupancy, 0..DEPTH
//   ovf      out  sticky: a push was attempted while full
//   last     out  final beat of a burst (STREAM_PRODUCER_LAST_EN only)
// ---------------------------------------------------------------------------
module stream_producer #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int BURST_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_full,
    output logic                       vld,
    input  logic                       rdy,
    output logic [WIDTH-1:0]           data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf
`ifdef STREAM_PRODUCER_LAST_EN
    ,
    output logic                       last
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             ovf_q;
    logic             push;
    logic             pop;

    // Every output comes from registered state only. There is no
    // combinational path from rdy or wr_en to any output.
    assign vld     = (level_q != '0);
    assign wr_full = (level_q == LW'(DEPTH));
    assign data    = vld ? mem[rd_ptr] : '0;
    assign level   = level_q;
    assign ovf     = ovf_q;

    assign push = wr_en && !wr_full;
    assign pop  = vld && rdy;

    // Storage is not reset. data is forced to 0 while the FIFO is empty, so
    // stale entries are never visible on the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of 2, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            // A push refused because the FIFO was full is latched until reset.
            // This also covers a simultaneous pop: wr_full was already set.
            if (wr_en && wr_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef STREAM_PRODUCER_LAST_EN
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);

    logic [CW-1:0] burst_cnt;

    // Counts transferred beats within the current burst. It only moves on a
    // transfer, so `last` stays stable alongside data under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (pop) begin
            burst_cnt <= (burst_cnt == CNT_MAX) ? '0 : burst_cnt + CW'(1);
        end
    end

    assign last = vld && (burst_cnt == CNT_MAX);
`endif

endmodule

// File: tb/tb_stream_producer.sv
// ---------------------------------------------------------------------------
// tb_stream_producer
//
// Self-checking bench for stream_producer. A queue-based reference model
// tracks what the FIFO must hold. A negedge compare process checks every
// output against that model on each cycle. Directed sequences also pin
// literal values.
// ---------------------------------------------------------------------------
module tb_stream_producer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int BLEN  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   wr_en = 1'b0;
  logic [W-1:0]           wr_data = '0;
  logic                   rdy = 1'b0;
  logic                   wr_full;
  logic                   vld;
  logic [W-1:0]           data;
  logic [$clog2(DEPTH):0] level;
  logic                   ovf;
`ifdef STREAM_PRODUCER_LAST_EN
  logic                   last;
`endif

  stream_producer #(.WIDTH(W), .DEPTH(DEPTH), .BURST_LEN(BLEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .wr_full (wr_full),
    .vld     (vld),
    .rdy     (rdy),
    .data    (data),
    .level   (level),
    .ovf     (ovf)
`ifdef STREAM_PRODUCER_LAST_EN
    ,
    .last    (last)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // FIFO contents as a plain queue, a sticky overflow flag, and the count of
  // beats transferred modulo the burst length.
  logic [W-1:0] exp_q[$];
  bit           m_ovf;
  int           m_beats;
  bit           m_pop;
  bit           m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ovf   = 1'b0;
      m_beats = 0;
    end else begin
      m_pop  = (exp_q.size() != 0) && rdy;
      m_push = wr_en && (exp_q.size() < DEPTH);
      if (wr_en && !m_push) m_ovf = 1'b1;
      if (m_pop) begin
        void'(exp_q.pop_front());
        m_beats = (m_beats + 1) % BLEN;
      end
      if (m_push) exp_q.push_back(wr_data);
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [W-1:0] rx_q[$];
  int           last_beats[$];
  int           beat_no = 0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      check("vld", vld, exp_q.size() != 0);
      check("data", data, (exp_q.size() != 0) ? exp_q[0] : '0);
      check("level", level, exp_q.size());
      check("wr_full", wr_full, exp_q.size() == DEPTH);
      check("ovf", ovf, m_ovf);
`ifdef STREAM_PRODUCER_LAST_EN
      check("last", last, (exp_q.size() != 0) && (m_beats == BLEN - 1));
`endif
      if (stall_prev) begin
        check("stall_vld", vld, 1'b1);
        check("stall_data", data, prev_data);
      end
      stall_prev = vld && !rdy;
      prev_data  = data;
      if (vld && rdy) begin
        rx_q.push_back(data);
        beat_no++;
`ifdef STREAM_PRODUCER_LAST_EN
        if (last) last_beats.push_back(beat_no);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic apply_reset();
    wr_en = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst_vld", vld, 1'b0);
    check("rst_data", data, 32'h0);
    check("rst_level", level, 0);
    check("rst_wr_full", wr_full, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    cyc();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] base;
  int           sent;

  initial begin
    // Reset with rdy high. A single word shows up one edge after its push.
    rdy = 1'b1;
    cyc();
    apply_reset();
    push(32'hDEADBEEF);
    check("t1_vld", vld, 1'b1);
    check("t1_data", data, 32'hDEADBEEF);
    cyc();
    check("t1_vld_drop", vld, 1'b0);

    // Fill under backpressure, then drain in order.
    rdy = 1'b0;
    for (int i = 1; i <= 4; i++) push(W'(i));
    check("t2_full", wr_full, 1'b1);
    check("t2_level", level, 4);
    rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t2_order", data, W'(i));
      cyc();
    end
    check("t2_vld_end", vld, 1'b0);
    check("t2_level_end", level, 0);

    // Push into a full FIFO: the word is lost and ovf sticks.
    rdy = 1'b0;
    for (int i = 1; i <= 4; i++) push(W'(i));
    push(32'h5);
    check("t3_ovf", ovf, 1'b1);
    check("t3_level", level, 4);
    rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_order", data, W'(i));
      cyc();
    end
    check("t3_vld_end", vld, 1'b0);
    check("t3_ovf_sticky", ovf, 1'b1);
    apply_reset();

    // Push and pop together while full: the pop happens and the push is dropped.
    rdy = 1'b0;
    for (int i = 1; i <= 4; i++) push(W'(i));
    wr_en   = 1'b1;
    wr_data = 32'h9;
    rdy     = 1'b1;
    cyc();
    wr_en = 1'b0;
    check("t5_level", level, 3);
    check("t5_ovf", ovf, 1'b1);
    check("t5_head", data, 32'h2);
    for (int i = 2; i <= 4; i++) begin
      check("t5_order", data, W'(i));
      cyc();
    end
    check("t5_vld_end", vld, 1'b0);
    apply_reset();

    // Push and pop together at level 1: the new word becomes the head.
    rdy = 1'b0;
    push(32'hA);
    wr_en   = 1'b1;
    wr_data = 32'hB;
    rdy     = 1'b1;
    cyc();
    wr_en = 1'b0;
    check("lvl1_head", data, 32'hB);
    check("lvl1_level", level, 1);
    cyc();
    check("lvl1_vld_end", vld, 1'b0);

    // Random rdy over 100 pushes of an incrementing count. Pushes are issued
    // only when the model has room, so the received sequence must have no gaps.
    rx_q.delete();
    base = 32'h100;
    sent = 0;
    for (int k = 0; k < 3000 && sent < 100; k++) begin
      rdy = 1'($urandom_range(0, 1));
      if (exp_q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        wr_en   = 1'b1;
        wr_data = base + W'(sent);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      cyc();
    end
    wr_en = 1'b0;
    rdy   = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) cyc();
    check("t4_sent", sent, 100);
    check("t4_rx_count", rx_q.size(), 100);
    for (int i = 0; i < rx_q.size(); i++) check("t4_seq", rx_q[i], base + W'(i));
    check("t4_no_ovf", ovf, 1'b0);

`ifdef STREAM_PRODUCER_LAST_EN
    // Burst marking over 8 back-to-back beats, then a reset partway through a burst.
    apply_reset();
    beat_no = 0;
    last_beats.delete();
    rdy = 1'b1;
    for (int i = 1; i <= 8; i++) push(W'(i));
    cyc();
    check("t6_last_count", last_beats.size(), 2);
    if (last_beats.size() == 2) begin
      check("t6_last_a", last_beats[0], 4);
      check("t6_last_b", last_beats[1], 8);
    end
    push(32'h1);
    push(32'h2);
    cyc();
    apply_reset();
    beat_no = 0;
    last_beats.delete();
    for (int i = 1; i <= 4; i++) push(W'(i));
    cyc();
    check("t6_rst_last_count", last_beats.size(), 1);
    if (last_beats.size() == 1) check("t6_rst_last", last_beats[0], 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
